// File: rtl/rgmii_idelay_cal.sv
// ---------------------------------------------------------------------------
// rgmii_idelay_cal
//
// Calibration controller for the RGMII receive input-delay path. Once the
// delay-control block reports ready, every tap of the delay line is loaded
// in turn. After each load the controller waits for the line to settle,
// then scores the tap with a number of training-pattern comparisons. The
// longest contiguous run of passing taps is kept, and its centre is loaded
// as the final delay. If no run is long enough, or ready never arrives, a
// fixed default tap is loaded and the failure is flagged.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   start          one-cycle pulse, begins or repeats a calibration
//   idelayctrl_rdy delay-control ready (asynchronous, synchronised here)
//   sample_valid   the pattern checker produced a comparison this cycle
//   sample_ok      that comparison matched (qualified by sample_valid)
//   dly_ld         one-cycle load strobe to the delay primitive
//   dly_cntvalue   tap presented with dly_ld, held between loads
//   cal_busy       calibration in progress
//   cal_done       last calibration succeeded (sticky until next start)
//   cal_fail       last calibration failed (sticky until next start)
//   win_start      first tap of the chosen window
//   win_len        length of the chosen window, 0 on failure
// ---------------------------------------------------------------------------
module rgmii_idelay_cal #(
    parameter int TAP_W         = 5,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLES       = 4,
    parameter int MIN_WINDOW    = 4,
    parameter int DEFAULT_TAP   = 16,
    parameter int RDY_TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             idelayctrl_rdy,
    input  logic             sample_valid,
    input  logic             sample_ok,
    output logic             dly_ld,
    output logic [TAP_W-1:0] dly_cntvalue,
    output logic             cal_busy,
    output logic             cal_done,
    output logic             cal_fail,
    output logic [TAP_W-1:0] win_start,
    output logic [TAP_W:0]   win_len
);

    // Run lengths need one extra bit so a run covering every tap fits.
    localparam int LEN_W = TAP_W + 1;
    localparam int TO_W  = $clog2(RDY_TIMEOUT + 1);
    localparam logic [TAP_W-1:0] TAP_MAX = {TAP_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        LOAD,
        SETTLE,
        SAMPLE,
        EVAL,
        APPLY,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic             rdy_meta;
    logic             rdy_sync;
    logic [TAP_W-1:0] tap;
    logic [TO_W-1:0]  timeout_cnt;
    logic [7:0]       settle_cnt;
    logic [7:0]       sample_cnt;
    logic             tap_pass;
    logic [TAP_W-1:0] run_start;
    logic [LEN_W-1:0] run_len;
    logic [TAP_W-1:0] best_start;
    logic [LEN_W-1:0] best_len;
    logic [TAP_W-1:0] cnt_hold;

    logic             abort;
    logic [TAP_W-1:0] eval_start;
    logic [LEN_W-1:0] eval_len;
    logic             eval_close;
    logic             apply_ok;
    logic [TAP_W-1:0] apply_tap;

    // Two-flop synchroniser for the asynchronous ready from IDELAYCTRL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_meta <= 1'b0;
            rdy_sync <= 1'b0;
        end else begin
            rdy_meta <= idelayctrl_rdy;
            rdy_sync <= rdy_meta;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the load strobe. Losing ready anywhere in the
    // per-tap loop abandons the sweep, because taps scored while the delay
    // line was not calibrated cannot be trusted.
    always_comb begin
        next_state = state;
        dly_ld     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (rdy_sync) begin
                    next_state = LOAD;
                end else if (timeout_cnt == TO_W'(RDY_TIMEOUT - 1)) begin
                    next_state = APPLY;
                end
            end
            LOAD: begin
                dly_ld     = 1'b1;
                next_state = rdy_sync ? SETTLE : WAIT_RDY;
            end
            SETTLE: begin
                if (!rdy_sync) begin
                    next_state = WAIT_RDY;
                end else if (settle_cnt == 8'(SETTLE_CYCLES - 1)) begin
                    next_state = SAMPLE;
                end
            end
            SAMPLE: begin
                if (!rdy_sync) begin
                    next_state = WAIT_RDY;
                end else if (sample_valid && (sample_cnt == 8'(SAMPLES - 1))) begin
                    next_state = EVAL;
                end
            end
            EVAL: begin
                if (!rdy_sync) begin
                    next_state = WAIT_RDY;
                end else if (tap == TAP_MAX) begin
                    next_state = APPLY;
                end else begin
                    next_state = LOAD;
                end
            end
            APPLY: begin
                dly_ld     = 1'b1;
                next_state = DONE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Run bookkeeping for the tap being evaluated. A passing tap extends
    // (or opens) the current run; the run is closed on a failing tap or at
    // the top tap so that a run reaching the end of the line still counts.
    // The centre uses (len-1)>>1 so it always lies inside the window and
    // therefore never exceeds the top tap.
    always_comb begin
        abort      = 1'b0;
        eval_start = run_start;
        eval_len   = run_len;
        eval_close = 1'b0;
        apply_ok   = 1'b0;
        apply_tap  = TAP_W'(DEFAULT_TAP);

        if ((state == LOAD) || (state == SETTLE) || (state == SAMPLE) || (state == EVAL)) begin
            abort = !rdy_sync;
        end

        if (tap_pass) begin
            eval_len = run_len + LEN_W'(1);
            if (run_len == '0) begin
                eval_start = tap;
            end
        end
        eval_close = !tap_pass || (tap == TAP_MAX);

        apply_ok = (best_len >= LEN_W'(MIN_WINDOW));
        if (apply_ok) begin
            apply_tap = best_start + TAP_W'((best_len - LEN_W'(1)) >> 1);
        end
    end

    // The tap shown to the primitive follows the strobe; between strobes
    // the last loaded value is held.
    always_comb begin
        dly_cntvalue = cnt_hold;
        if (state == LOAD) begin
            dly_cntvalue = tap;
        end else if (state == APPLY) begin
            dly_cntvalue = apply_tap;
        end
    end

    // Counters, run statistics and the sticky status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap         <= '0;
            timeout_cnt <= '0;
            settle_cnt  <= '0;
            sample_cnt  <= '0;
            tap_pass    <= 1'b1;
            run_start   <= '0;
            run_len     <= '0;
            best_start  <= '0;
            best_len    <= '0;
            cnt_hold    <= TAP_W'(DEFAULT_TAP);
            cal_busy    <= 1'b0;
            cal_done    <= 1'b0;
            cal_fail    <= 1'b0;
            win_start   <= '0;
            win_len     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cal_done    <= 1'b0;
                        cal_fail    <= 1'b0;
                        cal_busy    <= 1'b1;
                        tap         <= '0;
                        timeout_cnt <= '0;
                        run_start   <= '0;
                        run_len     <= '0;
                        best_start  <= '0;
                        best_len    <= '0;
                    end
                end
                WAIT_RDY: begin
                    if (!rdy_sync) begin
                        timeout_cnt <= timeout_cnt + TO_W'(1);
                    end
                end
                LOAD: begin
                    cnt_hold   <= tap;
                    settle_cnt <= '0;
                    sample_cnt <= '0;
                    tap_pass   <= 1'b1;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 8'd1;
                end
                SAMPLE: begin
                    if (sample_valid) begin
                        sample_cnt <= sample_cnt + 8'd1;
                        if (!sample_ok) begin
                            tap_pass <= 1'b0;
                        end
                    end
                end
                EVAL: begin
                    if (eval_close) begin
                        // Strictly greater: on a tie the earlier run stays.
                        if (eval_len > best_len) begin
                            best_start <= eval_start;
                            best_len   <= eval_len;
                        end
                        run_len <= '0;
                    end else begin
                        run_start <= eval_start;
                        run_len   <= eval_len;
                    end
                    if (tap != TAP_MAX) begin
                        tap <= tap + TAP_W'(1);
                    end
                end
                APPLY: begin
                    cnt_hold <= apply_tap;
                    cal_busy <= 1'b0;
                    if (apply_ok) begin
                        cal_done  <= 1'b1;
                        win_start <= best_start;
                        win_len   <= best_len;
                    end else begin
                        cal_fail <= 1'b1;
                        win_len  <= '0;
                    end
                end
                default: begin
                end
            endcase

            // Ready loss overrides whatever the loop state was doing and
            // restarts the sweep from the bottom tap.
            if (abort) begin
                tap         <= '0;
                timeout_cnt <= '0;
                run_start   <= '0;
                run_len     <= '0;
                best_start  <= '0;
                best_len    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rgmii_idelay_cal.sv
// ---------------------------------------------------------------------------
// tb_rgmii_idelay_cal
//
// Directed bench for rgmii_idelay_cal. A small pattern-checker model scores
// each tap from a pass mask indexed by the most recently loaded tap. Every
// load strobe is logged so the sweep order and final tap can be checked
// against hand-computed values.
// ---------------------------------------------------------------------------
module tb_rgmii_idelay_cal;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       idelayctrl_rdy = 1'b0;
    logic       sample_valid = 1'b0;
    logic       sample_ok = 1'b0;
    logic       dly_ld;
    logic [4:0] dly_cntvalue;
    logic       cal_busy;
    logic       cal_done;
    logic       cal_fail;
    logic [4:0] win_start;
    logic [5:0] win_len;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] pass_mask = 32'h0;
    logic [4:0]  cur_tap = 5'd0;
    int          cyc = 0;
    bit          hold_valid = 1'b0;
    int          ld_vals[$];

    rgmii_idelay_cal dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .idelayctrl_rdy (idelayctrl_rdy),
        .sample_valid   (sample_valid),
        .sample_ok      (sample_ok),
        .dly_ld         (dly_ld),
        .dly_cntvalue   (dly_cntvalue),
        .cal_busy       (cal_busy),
        .cal_done       (cal_done),
        .cal_fail       (cal_fail),
        .win_start      (win_start),
        .win_len        (win_len)
    );

    always #5 clk = ~clk;

    // Pattern-checker model: logs each load strobe, remembers the tap it
    // carried, and produces comparisons on two of every three cycles.
    always @(negedge clk) begin
        if (dly_ld) begin
            ld_vals.push_back(int'(dly_cntvalue));
            cur_tap = dly_cntvalue;
        end
        cyc = cyc + 1;
        sample_valid = !hold_valid && ((cyc % 3) != 0);
        sample_ok = pass_mask[cur_tap];
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run = tests_run + 1;
        if (observed != expected) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Loads a pass mask, clears the strobe log and pulses start.
    task automatic applyStimulus(input logic [31:0] mask);
        pass_mask = mask;
        ld_vals.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (cal_busy && (n < 5000)) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_finished"}, int'(n < 5000), 1);
    endtask

    task automatic waitLoads(input string tag, input int count);
        int n;
        n = 0;
        while ((ld_vals.size() < count) && (n < 5000)) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_reached"}, int'(n < 5000), 1);
    endtask

    task automatic checkResult(input string tag, input int ld_count, input int fin,
                               input int ws, input int wl, input int done, input int fail);
        checkOutput({tag, "_ld_count"}, ld_vals.size(), ld_count);
        if (ld_vals.size() > 0) begin
            checkOutput({tag, "_final_ld"}, ld_vals[ld_vals.size() - 1], fin);
        end
        checkOutput({tag, "_cntvalue"}, int'(dly_cntvalue), fin);
        checkOutput({tag, "_done"}, int'(cal_done), done);
        checkOutput({tag, "_fail"}, int'(cal_fail), fail);
        checkOutput({tag, "_busy"}, int'(cal_busy), 0);
        if (done == 1) begin
            checkOutput({tag, "_win_start"}, int'(win_start), ws);
        end
        checkOutput({tag, "_win_len"}, int'(win_len), wl);
    endtask

    // Counts strobes that break the 0..31 ascending sweep starting at base.
    task automatic checkSweep(input string tag, input int base);
        int bad;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if ((base + i) >= ld_vals.size()) begin
                bad++;
            end else if (ld_vals[base + i] != i) begin
                bad++;
            end
        end
        checkOutput({tag, "_sweep_order"}, bad, 0);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("reset_cntvalue", int'(dly_cntvalue), 16);
        checkOutput("reset_ld", int'(dly_ld), 0);
        checkOutput("reset_busy", int'(cal_busy), 0);
        checkOutput("reset_done", int'(cal_done), 0);
        checkOutput("reset_fail", int'(cal_fail), 0);
        checkOutput("reset_win_len", int'(win_len), 0);
        rst = 1'b0;
        idelayctrl_rdy = 1'b1;
        repeat (4) @(negedge clk);

        // 1: taps 10..20 pass, centre 10 + (10>>1) = 15
        applyStimulus(32'h001F_FC00);
        waitDone("s1");
        checkSweep("s1", 0);
        checkResult("s1", 33, 15, 10, 11, 1, 0);

        // 2: equal runs 3..6 and 12..15, earlier kept, centre 3 + 1 = 4
        applyStimulus(32'h0000_F078);
        waitDone("s2");
        checkResult("s2", 33, 4, 3, 4, 1, 0);

        // 3: everything fails
        applyStimulus(32'h0000_0000);
        waitDone("s3");
        checkResult("s3", 33, 16, 0, 0, 0, 1);

        // 4a: run at the top taps 28..31, centre 28 + 1 = 29
        applyStimulus(32'hF000_0000);
        waitDone("s4a");
        checkResult("s4a", 33, 29, 28, 4, 1, 0);

        // 4b: run 29..31 is only 3 long
        applyStimulus(32'hE000_0000);
        waitDone("s4b");
        checkResult("s4b", 33, 16, 0, 0, 0, 1);

        // 5a: ready never arrives, only the fallback load is issued
        idelayctrl_rdy = 1'b0;
        repeat (4) @(negedge clk);
        applyStimulus(32'h001F_FC00);
        waitDone("s5a");
        checkResult("s5a", 1, 16, 0, 0, 0, 1);

        // 5b: ready dropped while sampling tap 7, sweep restarts at tap 0
        idelayctrl_rdy = 1'b1;
        repeat (4) @(negedge clk);
        applyStimulus(32'h001F_FC00);
        waitLoads("s5b_tap7", 8);
        hold_valid = 1'b1;
        repeat (12) @(negedge clk);
        idelayctrl_rdy = 1'b0;
        repeat (6) @(negedge clk);
        idelayctrl_rdy = 1'b1;
        hold_valid = 1'b0;
        waitDone("s5b");
        checkSweep("s5b", 8);
        checkResult("s5b", 41, 15, 10, 11, 1, 0);

        // 6a: asynchronous reset in the middle of settling at tap 9
        applyStimulus(32'h001F_FC00);
        waitLoads("s6a_tap9", 10);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("s6a_ld", int'(dly_ld), 0);
        checkOutput("s6a_cntvalue", int'(dly_cntvalue), 16);
        checkOutput("s6a_busy", int'(cal_busy), 0);
        checkOutput("s6a_done", int'(cal_done), 0);
        checkOutput("s6a_fail", int'(cal_fail), 0);
        checkOutput("s6a_win_start", int'(win_start), 0);
        checkOutput("s6a_win_len", int'(win_len), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 6b: a start pulse during a sweep is ignored
        applyStimulus(32'h001F_FC00);
        waitLoads("s6b_tap5", 6);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("s6b");
        checkSweep("s6b", 0);
        checkResult("s6b", 33, 15, 10, 11, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rgmii_idelay_cal.md
Name: rgmii_idelay_cal

Overview:
- Calibration controller for the RGMII receive input-delay path (IDELAYE2 in VAR_LOAD mode, gated by IDELAYCTRL ready).
- After the delay-control block reports ready, sweeps every delay tap and checks a training pattern at each tap.
- Finds the longest contiguous run of passing taps and loads the centre of that run.
- Sits between the RX IDDR capture/pattern checker and the delay primitive; the MAC is held off until cal_done.

Parameters:
TAP_W, 5, tap value width; taps 0..2^TAP_W-1
SETTLE_CYCLES, 8, clk cycles waited after each tap load before sampling (1..255)
SAMPLES, 4, sample_valid beats checked per tap (1..255)
MIN_WINDOW, 4, minimum passing-run length for success
DEFAULT_TAP, 16, tap loaded on failure and at reset
RDY_TIMEOUT, 1024, clk cycles to wait for ready before failing

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse: begin or redo calibration
idelayctrl_rdy  in  1  delay-control ready, asynchronous; 2-flop synchronised internally
sample_valid  in  1  pattern checker produced a comparison this cycle
sample_ok  in  1  comparison matched; qualified by sample_valid
dly_ld  out  1  one-cycle load strobe to the delay primitive
dly_cntvalue  out  TAP_W  tap value presented with dly_ld; held stable between loads
cal_busy  out  1  calibration in progress
cal_done  out  1  last calibration succeeded; sticky until next start
cal_fail  out  1  last calibration failed; sticky until next start
win_start  out  TAP_W  first tap of the chosen window
win_len  out  TAP_W+1  length of the chosen window; 0 on failure

Behaviour:
- Reset, immediate and asynchronous: FSM=IDLE; dly_ld=0; dly_cntvalue=DEFAULT_TAP; cal_busy=0; cal_done=0; cal_fail=0; win_start=0; win_len=0; all counters and run statistics cleared.
- States: IDLE, WAIT_RDY, LOAD, SETTLE, SAMPLE, EVAL, APPLY, DONE.
- IDLE/DONE + start -> WAIT_RDY:
  - Clear cal_done, cal_fail, run statistics and timeout counter.
  - Set tap=0 and cal_busy=1.
  - start is ignored in every other state.
- WAIT_RDY:
  - Synchronised ready=1 -> LOAD.
  - Otherwise count cycles; when the count reaches RDY_TIMEOUT, load DEFAULT_TAP via APPLY and set cal_fail.
- LOAD (1 cycle): dly_ld=1, dly_cntvalue=tap -> SETTLE.
- SETTLE: wait exactly SETTLE_CYCLES cycles -> SAMPLE. No sample_valid is consumed in SETTLE.
- SAMPLE:
  - Count sample_valid beats.
  - tap_pass starts at 1 and is cleared by any beat with sample_ok=0.
  - After SAMPLES beats -> EVAL. No timeout in SAMPLE.
- EVAL (1 cycle):
  - Pass: if run_len=0, run_start=tap; run_len++.
  - Fail: close the current run.
  - Close rule: if run_len > best_len (strictly greater), best_start=run_start and best_len=run_len; then run_len=0. Ties keep the earlier run.
  - If tap = max tap, also close the run (so a run ending at the top tap counts), then -> APPLY.
  - Else tap++ -> LOAD.
- APPLY (1 cycle), dly_ld=1:
  - If best_len >= MIN_WINDOW: dly_cntvalue = best_start + ((best_len-1)>>1), truncated to TAP_W; cal_done=1; win_start=best_start; win_len=best_len.
  - Else: dly_cntvalue=DEFAULT_TAP; cal_fail=1; win_len=0.
  - Then -> DONE with cal_busy=0.
- Ready loss: if synchronised ready drops in LOAD, SETTLE, SAMPLE or EVAL:
  - Abort to WAIT_RDY and clear run statistics.
  - Restart at tap=0; the timeout counter restarts.
- Arithmetic:
  - Run and best lengths are TAP_W+1 bits, so a full run of 2^TAP_W taps is representable.
  - The centre calculation never exceeds max tap.
- Per-tap latency: 1 + SETTLE_CYCLES + (cycles to collect SAMPLES beats) + 1.
- cal_done and cal_fail are never both 1.

Test Plan:
1. Defaults; ready high; taps 10..20 pass, all others fail -> 32 dly_ld pulses with values 0..31, then a final pulse with value 15; win_start=10, win_len=11, cal_done=1.
2. Taps 3..6 and 12..15 pass (equal length 4) -> earlier run wins; final dly_cntvalue=4; win_start=3, win_len=4.
3. All taps fail (sample_ok=0) -> final dly_cntvalue=16, cal_fail=1, win_len=0, cal_done=0.
4. Taps 28..31 pass -> run closed at tap 31; win_start=28, win_len=4, final value 29. Same run as 29..31 only -> length 3 < 4 -> cal_fail=1.
5. Ready held low for 1024 cycles after start -> cal_fail=1, dly_cntvalue=16. Separately, ready dropped during SAMPLE at tap 7 and re-asserted -> sweep restarts at tap 0 and the result matches scenario 1.
6. rst asserted mid-SETTLE at tap 9 -> outputs take reset values immediately without a clock edge. A start pulse during a busy sweep -> ignored; sweep completes unchanged.
